// File: rtl/audio_pkg.sv
// Shared audio definitions: player states, 32-bit I2S frame constants and the
// sample-to-frame-word formatter used by the sample player.
package audio_pkg;

  localparam int unsigned FRAME_W   = 32;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned PAD_W     = 20;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } player_state_e;

  // Left-justified word: guard zero, 3-bit sign extension, sample, zero padding.
  function automatic logic [FRAME_W-1:0] format_sample(input logic [SAMPLE_W-1:0] d);
    return {1'b0, {3{d[SAMPLE_W-1]}}, d, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running I2S bit clock and word-select generator with a frame_tick
// marking the cycle whose closing edge raises lrclk.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SCLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic sclk,
  output logic lrclk,
  output logic frame_tick
);

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(SLOT_BITS - 1);

  logic [7:0] div_cnt_r;
  logic [4:0] bit_cnt_r;
  logic       sclk_r;
  logic       lrclk_r;
  logic       half_s;
  logic       sclk_fall_s;
  logic       lr_toggle_s;

  assign half_s      = (div_cnt_r == DIV_LAST);
  assign sclk_fall_s = half_s & sclk_r;
  assign lr_toggle_s = sclk_fall_s & (bit_cnt_r == BIT_LAST);

  // Divider, sclk toggle and per-slot bit counter; lrclk flips on the 32nd sclk fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 5'd0;
      sclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
    end else begin
      if (half_s) begin
        div_cnt_r <= 8'd0;
        sclk_r    <= ~sclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
      if (sclk_fall_s) begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_r <= 5'd0;
          lrclk_r   <= ~lrclk_r;
        end else begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
      end
    end
  end

  assign sclk       = sclk_r;
  assign lrclk      = lrclk_r;
  // Registered lrclk goes 0->1 at the edge closing this cycle.
  assign frame_tick = lr_toggle_s & ~lrclk_r;

endmodule

// File: rtl/i2s_sample_player.sv
// Plays a clip of signed 8-bit ROM samples, one per I2S frame, presenting each
// as a formatted 32-bit word that stays stable for the whole frame.
module i2s_sample_player
  import audio_pkg::*;
#(
  parameter int SCLK_DIV   = 8,
  parameter int SAMPLE_LEN = 5336,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              sclk,
  output logic              lrclk,
  output logic [31:0]       sample_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  player_state_e     state_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [31:0]       sample_r;
  logic              busy_r;
  logic              done_r;
  logic              frame_tick_s;

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .frame_tick (frame_tick_s)
  );

  // Playback FSM; trigger has priority and swallows a coincident frame_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rom_addr_r <= ADDR_ZERO;
      sample_r   <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (trigger) begin
        state_r    <= PLAY;
        rom_addr_r <= ADDR_ZERO;
        sample_r   <= 32'd0;
        busy_r     <= 1'b1;
      end else if (frame_tick_s) begin
        case (state_r)
          PLAY: begin
            // An address at or past the clip length ends playback, so rom_addr never exceeds it.
            if (rom_addr_r >= LAST_ADDR) begin
              state_r    <= IDLE;
              rom_addr_r <= ADDR_ZERO;
              sample_r   <= 32'd0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              rom_addr_r <= rom_addr_r + ADDR_ONE;
              sample_r   <= format_sample(rom_data);
            end
          end
          IDLE: begin
            sample_r <= 32'd0;
            busy_r   <= 1'b0;
          end
          default: begin
            state_r    <= IDLE;
            rom_addr_r <= ADDR_ZERO;
            sample_r   <= 32'd0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_addr   = rom_addr_r;
  assign sample_out = sample_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_i2s_sample_player.sv
// Self-checking bench for i2s_sample_player: clock timing, formatting,
// clip end, retrigger, trigger on a frame tick and reset mid-play.
module tb_i2s_sample_player;

  localparam int ADDR_W = 13;

  logic              clk;
  logic              reset;
  logic              trigger;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              sclk;
  logic              lrclk;
  logic [31:0]       sample_out;
  logic              busy;
  logic              done;

  int checks;
  int failures;
  int done_cnt;
  logic [7:0]  rom [0:7];
  logic [31:0] exp_q [$];

  i2s_sample_player #(
    .SCLK_DIV   (8),
    .SAMPLE_LEN (4),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sample_out (sample_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sample ROM: data valid one clk after the address
  always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference format via sign extension and shift
  function automatic logic [31:0] exp_fmt(input logic [7:0] d);
    logic [31:0] s;
    s = {{24{d[7]}}, d};
    return (s << 20) & 32'h7FFF_FFFF;
  endfunction

  task automatic wait_frame(output logic ok);
    logic prev;
    prev = lrclk;
    ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (lrclk === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = lrclk;
    end
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, sample_out);
    end else begin
      e = exp_q.pop_front();
      if (sample_out !== e) begin
        failures++;
        $display("FAIL %s: sample_out got %h expected %h", name, sample_out, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, lrclk, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected 0000", {sclk, lrclk, busy, done});
    end
    checks++;
    if (rom_addr !== 13'd0) begin
      failures++;
      $display("FAIL reset_addr: got %0d expected 0", rom_addr);
    end
    checks++;
    if (sample_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_sample: got %h expected 0", sample_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_timing;
    int sr1, sr2, lr1, lr2;
    logic ps, pl;
    sr1 = -1; sr2 = -1; lr1 = -1; lr2 = -1;
    ps = sclk; pl = lrclk;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      if (sclk === 1'b1 && ps === 1'b0) begin
        if (sr1 < 0) sr1 = n;
        else if (sr2 < 0) sr2 = n;
      end
      if (lrclk === 1'b1 && pl === 1'b0) begin
        if (lr1 < 0) lr1 = n;
        else if (lr2 < 0) lr2 = n;
      end
      ps = sclk; pl = lrclk;
      if (lr2 >= 0) break;
    end
    checks++;
    if (sr1 != 8) begin failures++; $display("FAIL sclk_first_rise: got %0d expected 8", sr1); end
    checks++;
    if (sr2 - sr1 != 16) begin failures++; $display("FAIL sclk_period: got %0d expected 16", sr2 - sr1); end
    checks++;
    if (lr1 != 512) begin failures++; $display("FAIL lrclk_first_rise: got %0d expected 512", lr1); end
    checks++;
    if (lr2 - lr1 != 1024) begin failures++; $display("FAIL lrclk_period: got %0d expected 1024", lr2 - lr1); end
    checks++;
    if (sample_out !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_tick: sample_out %h busy %b expected 0 0", sample_out, busy);
    end
  endtask

  task automatic test_clip_end;
    logic ok;
    int d0;
    d0 = done_cnt;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_fmt(rom[k]));
    exp_q.push_back(32'd0);
    checks++;
    if (busy !== 1'b1 || rom_addr !== 13'd0) begin
      failures++;
      $display("FAIL clip_start: busy %b addr %0d expected 1 0", busy, rom_addr);
    end
    for (int k = 0; k < 5; k++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clip_frame_timeout: got none expected lrclk rise"); end
      pop_check("clip_sample");
      checks++;
      if (k < 4 && (rom_addr !== 13'(k + 1) || busy !== 1'b1)) begin
        failures++;
        $display("FAIL clip_addr: addr %0d busy %b expected %0d 1", rom_addr, busy, k + 1);
      end else if (k == 4 && (rom_addr !== 13'd0 || busy !== 1'b0 || done !== 1'b1)) begin
        failures++;
        $display("FAIL clip_end: addr %0d busy %b done %b expected 0 0 1", rom_addr, busy, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL done_single: done %b pulses %0d expected 0 1", done, done_cnt - d0);
    end
    wait_frame(ok);
    checks++;
    if (sample_out !== 32'd0 || busy !== 1'b0 || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL idle_after_clip: sample_out %h busy %b expected 0 0", sample_out, busy);
    end
  endtask

  task automatic test_retrigger;
    logic ok;
    int d0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_fmt(rom[k]));
    for (int k = 0; k < 3; k++) begin
      wait_frame(ok);
      pop_check("retrig_sample");
    end
    checks++;
    if (rom_addr !== 13'd3) begin failures++; $display("FAIL retrig_pre_addr: got %0d expected 3", rom_addr); end
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checks++;
    if (sample_out !== 32'd0 || rom_addr !== 13'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL retrig: sample %h addr %0d busy %b expected 0 0 1", sample_out, rom_addr, busy);
    end
    exp_q.delete();
    exp_q.push_back(exp_fmt(rom[0]));
    wait_frame(ok);
    pop_check("retrig_restart");
    checks++;
    if (rom_addr !== 13'd1 || done_cnt != d0) begin
      failures++;
      $display("FAIL retrig_after: addr %0d pulses %0d expected 1 0", rom_addr, done_cnt - d0);
    end
  endtask

  task automatic test_simultaneous;
    logic ok;
    repeat (1023) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checks++;
    if (lrclk !== 1'b1) begin failures++; $display("FAIL simul_align: lrclk %b expected 1", lrclk); end
    checks++;
    if (rom_addr !== 13'd0 || sample_out !== 32'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL simul: addr %0d sample %h busy %b expected 0 0 1", rom_addr, sample_out, busy);
    end
    exp_q.push_back(exp_fmt(rom[0]));
    exp_q.push_back(exp_fmt(rom[1]));
    for (int k = 0; k < 2; k++) begin
      wait_frame(ok);
      pop_check("simul_follow");
    end
    checks++;
    if (rom_addr !== 13'd2) begin failures++; $display("FAIL simul_addr: got %0d expected 2", rom_addr); end
  endtask

  task automatic test_reset_midplay;
    int d0, rise;
    logic pl;
    repeat (200) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if ({sclk, lrclk, busy, done} !== 4'b0000 || rom_addr !== 13'd0 || sample_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_midplay: ctl %b addr %0d sample %h expected 0", {sclk, lrclk, busy, done}, rom_addr, sample_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rise = -1;
    pl = lrclk;
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      if (lrclk === 1'b1 && pl === 1'b0) begin rise = n; break; end
      pl = lrclk;
    end
    checks++;
    if (rise != 512) begin failures++; $display("FAIL reset_lrclk_rise: got %0d expected 512", rise); end
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || sample_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_done: pulses %0d busy %b expected 0 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_cnt = 0;
    reset = 1'b1;
    trigger = 1'b0;
    rom[0] = 8'h80; rom[1] = 8'h7F; rom[2] = 8'h00; rom[3] = 8'hA5;
    rom[4] = 8'h11; rom[5] = 8'h22; rom[6] = 8'h33; rom[7] = 8'h44;
    test_reset();
    test_timing();
    test_clip_end();
    test_retrigger();
    test_simultaneous();
    test_reset_midplay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
